// File: rtl/onewire_alarm_ctrl_if.sv
// Sample/threshold inputs and alarm status outputs of the one-wire alarm sequencer.
// The master drives the inputs and the slave (the sequencer) drives the status outputs.
interface onewire_alarm_ctrl_if;
    logic       temp_vld;
    logic [7:0] temp;
    logic [7:0] th;
    logic [7:0] tl;
    logic       alarm_clr;
    logic       busy;
    logic       done;
    logic       hi_hit;
    logic       lo_hit;
    logic       alarm_flag;
    logic       sample_drop;

    modport master (
        output temp_vld, temp, th, tl, alarm_clr,
        input  busy, done, hi_hit, lo_hit, alarm_flag, sample_drop
    );

    modport slave (
        input  temp_vld, temp, th, tl, alarm_clr,
        output busy, done, hi_hit, lo_hit, alarm_flag, sample_drop
    );
endinterface

// File: rtl/onewire_alarm_ctrl.sv
// Threshold-alarm sequencer: time-shares one sign-magnitude comparator for temp>=th and tl>=temp,
// then debounces consecutive hits into the sticky alarm flag reported by ALARM SEARCH.
module onewire_comparator (
    input  logic [7:0] dataa,
    input  logic [7:0] datab,
    output logic       a_ge_b
);
    // Sign-magnitude ordering: any positive (including +0) beats any negative (including -0).
    always_comb begin
        a_ge_b = 1'b0;
        if (dataa[7] != datab[7])
            a_ge_b = ~dataa[7];
        else if (!dataa[7])
            a_ge_b = (dataa[6:0] >= datab[6:0]);
        else
            a_ge_b = (dataa[6:0] <= datab[6:0]);
    end
endmodule

module onewire_alarm_ctrl #(
    parameter int unsigned DEB_CNT = 2
) (
    input logic                  clk,
    input logic                  rst_n,
    onewire_alarm_ctrl_if.slave  bus
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] CMP_HI = 2'd1;
    localparam logic [1:0] CMP_LO = 2'd2;
    localparam logic [1:0] UPDATE = 2'd3;

    localparam logic [3:0] DEB_THR = 4'(DEB_CNT);

    logic [1:0] state;
    logic [1:0] state_nxt;
    logic [7:0] temp_q;
    logic [7:0] th_q;
    logic [7:0] tl_q;
    logic [7:0] cmp_a;
    logic [7:0] cmp_b;
    logic       a_ge_b;
    logic       hi_r;
    logic       lo_r;
    logic       hit;
    logic [3:0] cnt;
    logic [3:0] cnt_inc;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.temp_vld) state_nxt = CMP_HI;
            CMP_HI:  state_nxt = CMP_LO;
            CMP_LO:  state_nxt = UPDATE;
            default: state_nxt = IDLE;
        endcase
    end

    // CMP_HI evaluates temp >= th; every other state presents tl >= temp.
    always_comb begin
        cmp_a = tl_q;
        cmp_b = temp_q;
        if (state == CMP_HI) begin
            cmp_a = temp_q;
            cmp_b = th_q;
        end
    end

    onewire_comparator u_cmp (
        .dataa  (cmp_a),
        .datab  (cmp_b),
        .a_ge_b (a_ge_b)
    );

    assign hit     = hi_r | lo_r;
    assign cnt_inc = (cnt == 4'd15) ? 4'd15 : cnt + 4'd1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state           <= IDLE;
            temp_q          <= '0;
            th_q            <= '0;
            tl_q            <= '0;
            hi_r            <= 1'b0;
            lo_r            <= 1'b0;
            cnt             <= '0;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b0;
            bus.hi_hit      <= 1'b0;
            bus.lo_hit      <= 1'b0;
            bus.alarm_flag  <= 1'b0;
            bus.sample_drop <= 1'b0;
        end else begin
            state           <= state_nxt;
            bus.busy        <= (state_nxt != IDLE);
            bus.done        <= (state == UPDATE);
            bus.sample_drop <= bus.temp_vld & bus.busy;

            if (state == IDLE && bus.temp_vld) begin
                temp_q <= bus.temp;
                th_q   <= bus.th;
                tl_q   <= bus.tl;
            end
            if (state == CMP_HI) hi_r <= a_ge_b;
            if (state == CMP_LO) lo_r <= a_ge_b;
            if (state == UPDATE) begin
                bus.hi_hit <= hi_r;
                bus.lo_hit <= lo_r;
            end

            // A clear always wins over a coincident debounce update.
            if (bus.alarm_clr) begin
                cnt            <= '0;
                bus.alarm_flag <= 1'b0;
            end else if (state == UPDATE) begin
                if (hit) begin
                    cnt <= cnt_inc;
                    if (cnt_inc >= DEB_THR) bus.alarm_flag <= 1'b1;
                end else begin
                    cnt <= '0;
                end
            end
        end
    end
endmodule

// File: tb/tb_onewire_alarm_ctrl.sv
// Bench for onewire_alarm_ctrl: two instances (debounce 2 and 1) share stimulus and are
// compared every cycle against a transaction-level model, plus literal spot checks.
module tb_onewire_alarm_ctrl;
    localparam int DEB_A = 2;
    localparam int DEB_B = 1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       vld = 1'b0;
    logic       clr = 1'b0;
    logic [7:0] t_in = '0;
    logic [7:0] th_in = '0;
    logic [7:0] tl_in = '0;

    int pass_cnt = 0;
    int tot_cnt  = 0;

    always #5 clk = ~clk;

    onewire_alarm_ctrl_if ifa ();
    onewire_alarm_ctrl_if ifb ();

    assign ifa.temp_vld  = vld;
    assign ifa.temp      = t_in;
    assign ifa.th        = th_in;
    assign ifa.tl        = tl_in;
    assign ifa.alarm_clr = clr;
    assign ifb.temp_vld  = vld;
    assign ifb.temp      = t_in;
    assign ifb.th        = th_in;
    assign ifb.tl        = tl_in;
    assign ifb.alarm_clr = clr;

    onewire_alarm_ctrl #(.DEB_CNT(DEB_A)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa.slave));
    onewire_alarm_ctrl #(.DEB_CNT(DEB_B)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb.slave));

    typedef struct packed {
        int         left;   // cycles of the accepted sample still outstanding
        logic [7:0] pt;
        logic [7:0] ph;
        logic [7:0] pl;
        int         c0;
        int         c1;
        logic [1:0] flag;
        logic       busy;
        logic       done;
        logic       hi;
        logic       lo;
        logic       drop;
        logic       valid;
    } model_t;

    model_t m = '0;

    // Sign-magnitude to an integer ordering key where -0 sits just below +0.
    function automatic int key(input logic [7:0] v);
        int mag;
        mag = int'(v[6:0]);
        return v[7] ? (-2 * mag - 1) : (2 * mag);
    endfunction

    function automatic model_t step(input model_t cur, input logic rst, input logic v,
                                    input logic c, input logic [7:0] t, input logic [7:0] h,
                                    input logic [7:0] l);
        model_t n;
        n = cur;
        if (!rst) begin
            n = '0;
            n.valid = 1'b1;
            return n;
        end
        n.valid = 1'b1;
        n.done  = 1'b0;
        n.drop  = v && (cur.left > 0);
        if (cur.left == 1) begin
            n.hi   = key(cur.pt) >= key(cur.ph);
            n.lo   = key(cur.pl) >= key(cur.pt);
            n.done = 1'b1;
            if (n.hi || n.lo) begin
                n.c0 = (cur.c0 >= 15) ? 15 : cur.c0 + 1;
                n.c1 = (cur.c1 >= 15) ? 15 : cur.c1 + 1;
                if (n.c0 >= DEB_A) n.flag[0] = 1'b1;
                if (n.c1 >= DEB_B) n.flag[1] = 1'b1;
            end else begin
                n.c0 = 0;
                n.c1 = 0;
            end
        end
        if (c) begin
            n.c0   = 0;
            n.c1   = 0;
            n.flag = 2'b00;
        end
        if (cur.left > 0) begin
            n.left = cur.left - 1;
        end else if (v) begin
            n.pt   = t;
            n.ph   = h;
            n.pl   = l;
            n.left = 3;
        end
        n.busy = (n.left > 0);
        return n;
    endfunction

    always @(posedge clk) m <= step(m, rst_n, vld, clr, t_in, th_in, tl_in);

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        tot_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        if (m.valid) begin
            chk("a_busy", 8'(ifa.busy), 8'(m.busy));
            chk("a_done", 8'(ifa.done), 8'(m.done));
            chk("a_hi_hit", 8'(ifa.hi_hit), 8'(m.hi));
            chk("a_lo_hit", 8'(ifa.lo_hit), 8'(m.lo));
            chk("a_alarm_flag", 8'(ifa.alarm_flag), 8'(m.flag[0]));
            chk("a_sample_drop", 8'(ifa.sample_drop), 8'(m.drop));
            chk("b_busy", 8'(ifb.busy), 8'(m.busy));
            chk("b_done", 8'(ifb.done), 8'(m.done));
            chk("b_hi_hit", 8'(ifb.hi_hit), 8'(m.hi));
            chk("b_lo_hit", 8'(ifb.lo_hit), 8'(m.lo));
            chk("b_alarm_flag", 8'(ifb.alarm_flag), 8'(m.flag[1]));
            chk("b_sample_drop", 8'(ifb.sample_drop), 8'(m.drop));
        end
    end

    // Called at a falling edge; returns at the falling edge of the cycle where done shows.
    task automatic sample(input logic [7:0] t, input logic [7:0] h, input logic [7:0] l,
                          input logic clr_upd);
        vld   = 1'b1;
        t_in  = t;
        th_in = h;
        tl_in = l;
        @(negedge clk);
        vld = 1'b0;
        repeat (2) @(negedge clk);
        clr = clr_upd;
        @(negedge clk);
        clr = 1'b0;
    endtask

    function automatic logic [7:0] pick();
        case ($urandom_range(0, 7))
            0: return 8'h00;
            1: return 8'h80;
            2: return 8'h0A;
            3: return 8'h8A;
            4: return 8'h46;
            5: return 8'hC6;
            default: return 8'($urandom);
        endcase
    endfunction

    initial begin
        @(negedge clk);
        chk("reset_busy", 8'(ifa.busy), 8'h0);
        chk("reset_done", 8'(ifa.done), 8'h0);
        chk("reset_flag", 8'(ifa.alarm_flag), 8'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Nominal sample inside the window.
        sample(8'h19, 8'h46, 8'h0A, 1'b0);
        chk("t1_done", 8'(ifa.done), 8'h1);
        chk("t1_hits", {6'd0, ifa.hi_hit, ifa.lo_hit}, 8'h0);

        // Negative low threshold and debounce.
        sample(8'h85, 8'h46, 8'h8A, 1'b0);
        chk("t2_lo_miss", 8'(ifa.lo_hit), 8'h0);
        sample(8'h8C, 8'h46, 8'h8A, 1'b0);
        chk("t2_lo_hit1", 8'(ifa.lo_hit), 8'h1);
        chk("t2_flag_a1", 8'(ifa.alarm_flag), 8'h0);
        chk("t2_flag_b1", 8'(ifb.alarm_flag), 8'h1);
        sample(8'h8C, 8'h46, 8'h8A, 1'b0);
        chk("t2_flag_a2", 8'(ifa.alarm_flag), 8'h1);
        sample(8'h19, 8'h46, 8'h8A, 1'b0);
        chk("t2_sticky_hits", {6'd0, ifa.hi_hit, ifa.lo_hit}, 8'h0);
        chk("t2_sticky_flag", 8'(ifa.alarm_flag), 8'h1);

        // Equality and -0 versus +0.
        sample(8'h46, 8'h46, 8'h0A, 1'b0);
        chk("t3_eq_hi", 8'(ifa.hi_hit), 8'h1);
        sample(8'h80, 8'h46, 8'h00, 1'b0);
        chk("t3_neg0_lo", 8'(ifa.lo_hit), 8'h1);
        chk("t3_neg0_hi", 8'(ifa.hi_hit), 8'h0);

        // Sample arriving while busy is dropped.
        vld = 1'b1; t_in = 8'h19; th_in = 8'h46; tl_in = 8'h0A;
        @(negedge clk);
        vld = 1'b0;
        @(negedge clk);
        vld = 1'b1; t_in = 8'h8C;
        @(negedge clk);
        vld = 1'b0;
        chk("t4_drop", 8'(ifa.sample_drop), 8'h1);
        @(negedge clk);
        chk("t4_done", 8'(ifa.done), 8'h1);
        chk("t4_first_result", 8'(ifa.lo_hit), 8'h0);
        @(negedge clk);
        chk("t4_single_done", 8'(ifa.done), 8'h0);
        sample(8'h50, 8'h46, 8'h0A, 1'b0);
        chk("t4_b2b_first", 8'(ifa.hi_hit), 8'h1);
        sample(8'h05, 8'h46, 8'h0A, 1'b0);
        chk("t4_b2b_second", 8'(ifa.lo_hit), 8'h1);

        // Clear coinciding with the update.
        chk("t5_flag_before", 8'(ifa.alarm_flag), 8'h1);
        sample(8'h8C, 8'h46, 8'h8A, 1'b1);
        chk("t5_clr_flag", 8'(ifa.alarm_flag), 8'h0);
        chk("t5_clr_lo", 8'(ifa.lo_hit), 8'h1);
        sample(8'h8C, 8'h46, 8'h8A, 1'b0);
        chk("t5_after1", 8'(ifa.alarm_flag), 8'h0);
        sample(8'h8C, 8'h46, 8'h8A, 1'b0);
        chk("t5_after2", 8'(ifa.alarm_flag), 8'h1);

        // Reset during CMP_LO aborts the sequence.
        vld = 1'b1; t_in = 8'h50;
        @(negedge clk);
        vld = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("t6_rst_busy", 8'(ifa.busy), 8'h0);
        chk("t6_rst_flag", 8'(ifa.alarm_flag), 8'h0);
        @(negedge clk);
        chk("t6_no_done", 8'(ifa.done), 8'h0);
        sample(8'h8C, 8'h46, 8'h8A, 1'b0);
        chk("t6_done", 8'(ifa.done), 8'h1);
        chk("t6_deb1_flag", 8'(ifb.alarm_flag), 8'h1);
        chk("t6_deb2_flag", 8'(ifa.alarm_flag), 8'h0);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            rst_n = ($urandom_range(0, 99) != 0);
            vld   = ($urandom_range(0, 2) == 0);
            clr   = ($urandom_range(0, 24) == 0);
            t_in  = pick();
            th_in = pick();
            tl_in = pick();
            @(negedge clk);
        end
        rst_n = 1'b1;
        vld   = 1'b0;
        clr   = 1'b0;
        repeat (6) @(negedge clk);

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end
endmodule

// File: doc/onewire_alarm_ctrl.md
Name: onewire_alarm_ctrl

Overview:
Threshold-alarm sequencer for the one-wire temperature core. On each new temperature sample it time-shares one internal onewire_comparator instance: first temp vs TH, then TL vs temp. It applies a consecutive-hit debounce and maintains the sticky alarm flag that the ALARM SEARCH command reports. It sits between the conversion result register and the one-wire command/ROM logic.

Parameters:
DEB_CNT, 2, consecutive hit samples required to set alarm_flag; legal range 1..15 (1 means immediate set).

Ports:
clk  input  1  system clock
rst_n  input  1  synchronous active-low reset
temp_vld  input  1  one-cycle pulse: new conversion result on temp
temp  input  8  temperature, sign-magnitude (bit7 sign, bits6:0 magnitude)
th  input  8  high threshold, sign-magnitude
tl  input  8  low threshold, sign-magnitude
alarm_clr  input  1  one-cycle pulse: clear alarm_flag and debounce counter
busy  output  1  sequence in progress
done  output  1  one-cycle pulse: results updated
hi_hit  output  1  last sample temp >= th
lo_hit  output  1  last sample tl >= temp
alarm_flag  output  1  sticky debounced alarm
sample_drop  output  1  one-cycle pulse: temp_vld ignored because busy

Behaviour:
- Reset: one clock, synchronous and active-low. When rst_n=0 at a clk edge, state=IDLE, busy=0, done=0, hi_hit=0, lo_hit=0, alarm_flag=0, sample_drop=0, deb counter=0, latched operands=0. Reset mid-sequence aborts the sequence; no done pulse follows.
- FSM states: IDLE, CMP_HI, CMP_LO, UPDATE. Single comparator instance; operand mux is selected by state.
- IDLE: when temp_vld=1, latch temp_q/th_q/tl_q, then go to CMP_HI. Inputs are not sampled again until the next IDLE.
- CMP_HI: dataa=temp_q, datab=th_q; register hi_r=a_ge_b; go to CMP_LO.
- CMP_LO: dataa=tl_q, datab=temp_q; register lo_r=a_ge_b; go to UPDATE.
- UPDATE: hit=hi_r|lo_r. If hit, cnt=min(cnt+1,15), and set alarm_flag when the new cnt >= DEB_CNT. If not hit, cnt=0 and alarm_flag holds its value (sticky). hi_hit/lo_hit are loaded from hi_r/lo_r; done=1 for one cycle. Go to IDLE.
- Latency: temp_vld sampled at edge N. busy=1 for cycles N+1..N+3. done, hi_hit, lo_hit, and alarm_flag show new values in cycle N+4. A back-to-back temp_vld is accepted in cycle N+4, giving a throughput of 1 sample per 4 cycles.
- sample_drop: pulses one cycle after any temp_vld that arrives while busy=1. The dropped sample has no effect on any state.
- alarm_clr: clears alarm_flag and cnt on the next edge in any state. If it coincides with UPDATE, clear wins: alarm_flag=0 and cnt=0. hi_hit/lo_hit and done still update normally.
- Comparison semantics are those of onewire_comparator, signed sign-magnitude. -0 (0x80) compares less than +0 (0x00); this is accepted as-is.
- Misconfiguration tl > th is not checked; both hits may assert together, and the result still counts as one hit.
- All outputs are registered. No combinational path from inputs to outputs.

Test Plan:
1. DEB_CNT=2, th=0x46(+70), tl=0x0A(+10), temp=0x19(+25) pulse -> busy high 3 cycles; done in cycle N+4; hi_hit=0, lo_hit=0, alarm_flag=0.
2. DEB_CNT=2, tl=0x8A(-10), temp=0x85(-5) -> lo_hit=0. Then temp=0x8C(-12) twice -> lo_hit=1 both times; alarm_flag=0 after the first, 1 after the second. Next temp=0x19 -> hits=0, alarm_flag stays 1.
3. temp=th=0x46 -> hi_hit=1 (equality counts). temp=0x80 with tl=0x00 -> lo_hit=1.
4. temp_vld, then a second temp_vld 2 cycles later -> sample_drop pulse, exactly one done, results from the first sample. Back-to-back pulses at N and N+4 -> both accepted, two done pulses.
5. alarm_flag=1, hit sample with alarm_clr asserted during UPDATE -> alarm_flag=0 and cnt=0. The next hit with DEB_CNT=2 does not set the flag; the one after does.
6. rst_n=0 during CMP_LO -> all outputs 0 on the next edge, no done pulse. A new temp_vld afterwards completes normally. DEB_CNT=1: a single hit sets alarm_flag.
